dcache_ip_seg_writer: RTL and testbench

// - IP-side initiator for one external write port (DWriteEx/DAddrEx/DOutEx) of the shared Dcache.
// - Buffers words produced by one IP and drains them into that IP's 16-word segment.
// - Drains only while the Dcache control word (addr 20) shows REQ for this IP and not DIS.
// - One instance per IP (x = 1..4), placed between each IP core and the shared Dcache.

---
 rtl/dcache_ip_seg_writer_pkg.sv | 39 +++
 rtl/dcache_ip_seg_writer_ip_wr_fifo.sv | 50 +++++
 rtl/dcache_ip_seg_writer.sv | 133 +++++++++++++
 tb/tb_dcache_ip_seg_writer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_ip_seg_writer_pkg.sv
// Shared Dcache defines used by the per-IP segment writers.
// Holds the word size and logic constants, the control word address, the
// DIS/REQ bit positions inside the control word, each IP's segment base,
// and the writer FSM state encoding.
package dcache_ip_seg_writer_pkg;

  localparam int   WORD_SIZE      = 32;
  localparam logic LOGIC_ONE      = 1'b1;
  localparam logic LOGIC_ZERO     = 1'b0;

  localparam int   CTRL_WORD_ADDR = 20;

  // Control word bits run opposite to IP numbering: IP1 owns the highest bit.
  localparam int   DIS_BIT_IP1    = 15;
  localparam int   DIS_BIT_IP2    = 14;
  localparam int   DIS_BIT_IP3    = 13;
  localparam int   DIS_BIT_IP4    = 12;
  localparam int   REQ_BIT_IP1    = 11;
  localparam int   REQ_BIT_IP2    = 10;
  localparam int   REQ_BIT_IP3    = 9;
  localparam int   REQ_BIT_IP4    = 8;

  localparam int   SEG_BASE_IP1   = 48;
  localparam int   SEG_BASE_IP2   = 64;
  localparam int   SEG_BASE_IP3   = 80;
  localparam int   SEG_BASE_IP4   = 96;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } wr_state_e;

  // Segment base for IP number ip (1..4).
  function automatic int seg_base_for(input int ip);
    return SEG_BASE_IP1 + (ip - 1) * 16;
  endfunction

endpackage

// File: rtl/dcache_ip_seg_writer_ip_wr_fifo.sv
// ip_wr_fifo: synchronous show-ahead FIFO buffering IP words ahead of the
// Dcache write port.
// Ports: clk, rst_n (async, active-low, clears pointers only),
//        push/din write side, pop read side, dout = current head word,
//        full / empty status.
module ip_wr_fifo
  import dcache_ip_seg_writer_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [N-1:0] din,
  input  logic         pop,
  output logic [N-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic [N-1:0] mem [DEPTH];

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full)
        wp <= wp + 1'b1;
      if (pop && !empty)
        rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/dcache_ip_seg_writer.sv
// dcache_ip_seg_writer: buffers words from one IP and drains them into that
// IP's SEG_WORDS-word segment of the shared Dcache through one external
// write port, while the control word shows REQ and not DIS for this IP.
// Ports: CLK, RST_N (async, active-low); DIS/REQ control bits;
//        ip_valid/ip_data/ip_ready IP handshake;
//        DWriteE/DAddrE/DOutE Dcache write port (registered);
//        done (end-of-round pulse), seg_full, drop_cnt (saturating).
module dcache_ip_seg_writer
  import dcache_ip_seg_writer_pkg::*;
#(
  parameter int N          = WORD_SIZE,
  parameter int SEG_BASE   = SEG_BASE_IP1,
  parameter int SEG_WORDS  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         DIS,
  input  logic         REQ,
  input  logic         ip_valid,
  input  logic [N-1:0] ip_data,
  output logic         ip_ready,
  output logic         DWriteE,
  output logic [N-1:0] DAddrE,
  output logic [N-1:0] DOutE,
  output logic         done,
  output logic         seg_full,
  output logic [7:0]   drop_cnt
);

  localparam int            PW       = $clog2(SEG_WORDS) + 1;
  localparam logic [PW-1:0] PTR_END  = PW'(SEG_WORDS);
  localparam logic [PW-1:0] PTR_LAST = PW'(SEG_WORDS - 1);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  wr_state_e     st;
  logic          rq_q;
  logic          ds_q;
  logic          rq_d;
  logic          rq_rise;
  logic [PW-1:0] wr_ptr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [N-1:0]  fifo_dout;
  logic          push;
  logic          pop;

  assign ip_ready = RST_N && !fifo_full && !DIS;
  assign push     = ip_valid && ip_ready;
  assign rq_rise  = rq_q && !rq_d;
  // Must mirror the word-issuing branch of the XFER state below.
  assign pop      = (st == XFER) && !ds_q && rq_q && !fifo_empty &&
                    (wr_ptr != PTR_END);

  ip_wr_fifo #(
    .N     (N),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .din   (ip_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st       <= IDLE;
      rq_q     <= LOGIC_ZERO;
      ds_q     <= LOGIC_ZERO;
      rq_d     <= LOGIC_ZERO;
      wr_ptr   <= '0;
      seg_full <= LOGIC_ZERO;
      DWriteE  <= LOGIC_ZERO;
      DAddrE   <= N'(SEG_BASE);
      DOutE    <= '0;
      done     <= LOGIC_ZERO;
      drop_cnt <= '0;
    end else begin
      // Control input stage: REQ/DIS registered once before FSM use.
      rq_q    <= REQ;
      ds_q    <= DIS;
      rq_d    <= rq_q;
      DWriteE <= LOGIC_ZERO;
      done    <= LOGIC_ZERO;

      if (ip_valid && !ip_ready && !DIS)
        drop_cnt <= sat_inc(drop_cnt);

      // A fresh REQ round restarts at the bottom of the segment.
      if (rq_rise) begin
        wr_ptr   <= '0;
        seg_full <= LOGIC_ZERO;
      end

      case (st)
        IDLE: begin
          if (rq_q && !ds_q && !fifo_empty && !seg_full)
            st <= XFER;
        end
        XFER: begin
          if (ds_q) begin
            // Suspended, not finished: no done pulse, FIFO keeps its words.
            st <= IDLE;
          end else if (!rq_q || fifo_empty || (wr_ptr == PTR_END)) begin
            st   <= DONE;
            done <= LOGIC_ONE;
          end else begin
            // Output stage: word popped now is strobed on the next cycle.
            DWriteE <= LOGIC_ONE;
            DAddrE  <= N'(SEG_BASE) + N'(wr_ptr);
            DOutE   <= fifo_dout;
            wr_ptr  <= wr_ptr + 1'b1;
            if (wr_ptr == PTR_LAST) begin
              seg_full <= LOGIC_ONE;
              st       <= DONE;
              done     <= LOGIC_ONE;
            end
          end
        end
        DONE: st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ip_seg_writer.sv
module tb_dcache_ip_seg_writer;

  logic        CLK;
  logic        RST_N;
  logic        DIS;
  logic        REQ;
  logic        ip_valid;
  logic [31:0] ip_data;
  logic        ip_ready;
  logic        DWriteE;
  logic [31:0] DAddrE;
  logic [31:0] DOutE;
  logic        done;
  logic        seg_full;
  logic [7:0]  drop_cnt;

  dcache_ip_seg_writer #(
    .N          (32),
    .SEG_BASE   (48),
    .SEG_WORDS  (16),
    .FIFO_DEPTH (8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DIS      (DIS),
    .REQ      (REQ),
    .ip_valid (ip_valid),
    .ip_data  (ip_data),
    .ip_ready (ip_ready),
    .DWriteE  (DWriteE),
    .DAddrE   (DAddrE),
    .DOutE    (DOutE),
    .done     (done),
    .seg_full (seg_full),
    .drop_cnt (drop_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int nvec = 0;
  int nmis = 0;

  // Strobe monitor: sole writer of the capture queues.
  logic [31:0] got_addr [$];
  logic [31:0] got_data [$];
  int          got_cyc  [$];
  int          cyc_n  = 0;
  int          done_n = 0;

  always @(posedge CLK) begin
    #1;
    cyc_n = cyc_n + 1;
    if (DWriteE === 1'b1) begin
      got_addr.push_back(DAddrE);
      got_data.push_back(DOutE);
      got_cyc.push_back(cyc_n);
    end
    if (done === 1'b1) done_n = done_n + 1;
  end

  typedef struct {
    logic        dis;
    logic        req;
    logic        valid;
    logic [31:0] data;
    logic        exp_ready;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 1'b0; REQ = 1'b0; DIS = 1'b0; ip_valid = 1'b0; ip_data = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic push_word(input logic [31:0] d);
    int g;
    g = 0;
    @(negedge CLK);
    while (!ip_ready && g < 500) begin
      @(negedge CLK);
      g++;
    end
    if (!ip_ready) begin
      chk("push_timeout", {31'd0, ip_ready}, 32'd1);
      return;
    end
    ip_valid = 1'b1;
    ip_data  = d;
    @(posedge CLK);
    #1 ip_valid = 1'b0;
  endtask

  task automatic wait_strobes(input string nm, input int target, input int budget);
    int g;
    g = 0;
    while (got_addr.size() < target && g < budget) begin
      @(negedge CLK);
      g++;
    end
    if (got_addr.size() < target) chk(nm, got_addr.size(), target);
  endtask

  task automatic chk_strobes(input string nm, input int first, input int n,
                             input logic [31:0] addr0, input logic [31:0] data0);
    for (int i = 0; i < n; i++) begin
      if (first + i < got_addr.size()) begin
        chk({nm, "_addr"}, got_addr[first+i], addr0 + i);
        chk({nm, "_data"}, got_data[first+i], data0 + i);
      end else begin
        chk({nm, "_missing"}, got_addr.size(), first + i + 1);
      end
    end
  endtask

  initial begin
    int b;
    int d0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int d0;
    RST_N = 1'b0; REQ = 1'b0; DIS = 1'b0; ip_valid = 1'b0; ip_data = '0;

    // Overflow table: REQ=0 so nothing drains; depth 8 accepts 8 of 12.
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 32'hC0, 1'b1, 8'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'hC1, 1'b1, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 32'hC2, 1'b1, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 32'hC3, 1'b1, 8'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'hC4, 1'b1, 8'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'hC5, 1'b1, 8'd0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'hC6, 1'b1, 8'd0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'hC7, 1'b1, 8'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'hC8, 1'b0, 8'd1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'hC9, 1'b0, 8'd2};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 32'hCA, 1'b0, 8'd3};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 32'hCB, 1'b0, 8'd4};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 32'hCC, 1'b0, 8'd4};  // DIS offers are not drops
    tbl[13] = '{1'b0, 1'b0, 1'b0, 32'hCD, 1'b0, 8'd4};  // still full

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_ip_ready", {31'd0, ip_ready}, 32'd0);
    chk("rst_dwrite",   {31'd0, DWriteE},  32'd0);
    chk("rst_daddr",    DAddrE,            32'd48);
    chk("rst_dout",     DOutE,             32'd0);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_segfull",  {31'd0, seg_full}, 32'd0);
    chk("rst_drop",     {24'd0, drop_cnt}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Basic drain
    do_reset();
    b = got_addr.size(); d0 = done_n;
    push_word(32'hA);
    push_word(32'hB);
    push_word(32'hC);
    @(negedge CLK); REQ = 1'b1;
    wait_strobes("basic_timeout", b + 3, 100);
    repeat (6) @(negedge CLK);
    chk("basic_count", got_addr.size() - b, 32'd3);
    chk_strobes("basic", b, 3, 32'd48, 32'hA);
    if (got_cyc.size() >= b + 3) begin
      chk("basic_consec1", got_cyc[b+1] - got_cyc[b],   32'd1);
      chk("basic_consec2", got_cyc[b+2] - got_cyc[b+1], 32'd1);
    end
    chk("basic_done", done_n - d0, 32'd1);
    chk("basic_segfull", {31'd0, seg_full}, 32'd0);

    // Segment limit, then a second REQ round
    do_reset();
    b = got_addr.size();
    @(negedge CLK); REQ = 1'b1;
    for (int i = 0; i < 20; i++) push_word(32'h100 + i);
    wait_strobes("seg_timeout", b + 16, 400);
    repeat (10) @(negedge CLK);
    chk("seg_count", got_addr.size() - b, 32'd16);
    chk_strobes("seg", b, 16, 32'd48, 32'h100);
    chk("seg_full_set", {31'd0, seg_full}, 32'd1);
    REQ = 1'b0;
    repeat (3) @(negedge CLK);
    REQ = 1'b1;
    wait_strobes("seg2_timeout", b + 20, 100);
    repeat (10) @(negedge CLK);
    chk("seg2_count", got_addr.size() - b, 32'd20);
    chk_strobes("seg2", b + 16, 4, 32'd48, 32'h110);
    chk("seg2_segfull", {31'd0, seg_full}, 32'd0);

    // DIS mid-burst
    do_reset();
    b = got_addr.size();
    for (int i = 0; i < 6; i++) push_word(32'h200 + i);
    @(negedge CLK); REQ = 1'b1;
    d0 = done_n;
    wait_strobes("dis_timeout", b + 2, 100);
    DIS = 1'b1;
    #1;
    chk("dis_ip_ready", {31'd0, ip_ready}, 32'd0);
    repeat (8) @(negedge CLK);
    chk("dis_extra_le1", {31'd0, (got_addr.size() - b) <= 3}, 32'd1);
    chk("dis_no_done", done_n - d0, 32'd0);
    DIS = 1'b0;
    wait_strobes("dis_resume_timeout", b + 6, 100);
    repeat (6) @(negedge CLK);
    chk("dis_count", got_addr.size() - b, 32'd6);
    chk_strobes("dis", b, 6, 32'd48, 32'h200);
    chk("dis_done", done_n - d0, 32'd1);

    // Overflow table + drop saturation
    do_reset();
    b = got_addr.size();
    foreach (tbl[i]) begin
      @(negedge CLK);
      DIS = tbl[i].dis; REQ = tbl[i].req; ip_valid = tbl[i].valid; ip_data = tbl[i].data;
      #1;
      chk($sformatf("ovf_ready[%0d]", i), {31'd0, ip_ready}, {31'd0, tbl[i].exp_ready});
      @(posedge CLK);
      #1;
      chk($sformatf("ovf_drop[%0d]", i), {24'd0, drop_cnt}, {24'd0, tbl[i].exp_drop});
    end
    @(negedge CLK); DIS = 1'b0; ip_valid = 1'b1;
    repeat (260) @(negedge CLK);
    ip_valid = 1'b0;
    chk("drop_sat", {24'd0, drop_cnt}, 32'd255);
    REQ = 1'b1;
    wait_strobes("ovf_drain_timeout", b + 8, 100);
    repeat (6) @(negedge CLK);
    chk("ovf_drain_count", got_addr.size() - b, 32'd8);
    chk_strobes("ovf_drain", b, 8, 32'd48, 32'hC0);

    // Async reset mid-burst
    do_reset();
    b = got_addr.size();
    for (int i = 0; i < 5; i++) push_word(32'h300 + i);
    @(negedge CLK); REQ = 1'b1;
    wait_strobes("arst_timeout", b + 2, 100);
    RST_N = 1'b0;
    #1;
    chk("arst_dwrite", {31'd0, DWriteE}, 32'd0);
    chk("arst_ready",  {31'd0, ip_ready}, 32'd0);
    chk("arst_dout",   DOutE, 32'd0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    chk("arst_no_more", got_addr.size() - b, 32'd2);
    chk("arst_daddr", DAddrE, 32'd48);
    chk("arst_done", {31'd0, done}, 32'd0);

    // Simultaneous push/pop around FIFO_DEPTH-1 occupancy
    do_reset();
    b = got_addr.size();
    for (int i = 0; i < 7; i++) push_word(32'h400 + i);
    @(negedge CLK); REQ = 1'b1;
    for (int i = 7; i < 12; i++) push_word(32'h400 + i);
    wait_strobes("pp_timeout", b + 12, 200);
    repeat (6) @(negedge CLK);
    chk("pp_count", got_addr.size() - b, 32'd12);
    chk_strobes("pp", b, 12, 32'd48, 32'h400);
    chk("pp_drop", {24'd0, drop_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
